// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine draining an async FIFO read port
//
// Purpose: pops one FIFO word per frame and serialises it as 8N1 (or 8E1 when
// UART_TX_PARITY_EN is defined), back-to-back while data is available.
//
// Ports:
//   clk_i         transmit-domain clock (FIFO read clock)
//   rst_i         synchronous active-high reset
//   fifo_data_i   FIFO read data, valid while fifo_empty_i is low
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO pop strobe (combinational, one cycle per word)
//   clk_div_i     bit period minus one in clk_i cycles, latched per frame
//   tx_o          serial line, idle high, registered
//   busy_o        high while a frame is in progress
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).

module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  pop;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == div_q);

    // Pop from IDLE, or in the final cycle of STOP so the next start bit
    // follows the stop bit with no idle gap. Never pop while in reset.
    assign pop = !rst_i && !fifo_empty_i &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pop overrides the end-of-STOP/IDLE decision: load the word and
        // latch the divider so later clk_div_i changes leave this frame alone.
        if (pop) begin
            state_d = S_START;
            shreg_d = fifo_data_i;
            div_d   = clk_div_i;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data_i;
`endif
        end

        // tx is registered from the next state so the line changes on the
        // same edge the state does.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_rd_en_o = pop;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit engine that drains the read port of the transmit-side asynchronous FIFO and produces an 8N1 UART bitstream (optionally 8E1) on a single output line. Sits in the UART peripheral's transmit clock domain, directly downstream of the FIFO. Pops one word per frame and transmits back-to-back frames with no idle gap while data is available. The baud rate comes from a run-time divider input.

## Interface
- DATA_WIDTH, 8, width of FIFO word and number of data bits per frame.
- DIV_WIDTH, 16, width of the baud divider input.

- clk_i  in  1  transmit-domain clock, same clock as the FIFO read port.
- rst_i  in  1  synchronous, active-high reset.
- fifo_data_i  in  DATA_WIDTH  FIFO read data; valid combinationally whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_en_o  out  1  FIFO pop strobe, one cycle per word.
- clk_div_i  in  DIV_WIDTH  bit period minus one, in clk_i cycles. Value D gives D+1 cycles per bit.
- tx_o  out  1  serial line, idle high, registered.
- busy_o  out  1  high while a frame is in progress.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro described under Configuration.
- Pop rule: fifo_rd_en_o = !fifo_empty_i & (state==IDLE | last cycle of STOP). It is combinational and never asserted during reset.
  - On a pop edge, fifo_data_i is loaded into the shift register, clk_div_i is latched into the period register, and the FSM enters START.
  - clk_div_i changes mid-frame have no effect on that frame.
- Bit counter: counts 0..D; the state or bit advances when it reaches D, then the counter resets to 0.
- START: tx_o=0.
- DATA: DATA_WIDTH bits, LSB first. Shift right on each bit boundary. A 3-bit (clog2) index counts the data bits.
- PARITY: tx_o = ^data (even parity), computed at load time.
- STOP: tx_o=1 for one bit period.
  - At the end of STOP, go to START if fifo_empty_i=0 (the pop happens in that same cycle), otherwise go to IDLE.
- IDLE: tx_o=1.
- busy_o = (state != IDLE).
- D=0 is legal: 1 cycle per bit.

## Timing
- Reset values: tx_o=1, busy_o=0, fifo_rd_en_o=0, state=IDLE, counters=0.
- Latency: a pop at edge N (from IDLE) makes tx_o low from edge N, i.e. visible in cycle N+1.
- Frame length is exactly (DATA_WIDTH+2)*(D+1) cycles, or (DATA_WIDTH+3)*(D+1) with parity.
- Back-to-back frames: a stop bit of exactly D+1 cycles is followed immediately by the next start bit, with zero idle cycles.
- FIFO becomes non-empty in the same cycle STOP ends: the pop happens and the frame is back-to-back.
- FIFO becomes non-empty during a frame: no pop until the last STOP cycle.
- Reset mid-frame: at the next edge tx_o=1 and state=IDLE. The word already popped is discarded, and no pop occurs in the reset cycle.
- After reset deasserts, a non-empty FIFO is popped in the first non-reset cycle.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: an even-parity bit is inserted between the last data bit and stop; frame is 8E1 for DATA_WIDTH=8.
  - Undefined: the PARITY state and the parity logic are absent; frame is 8N1.

## Test plan
- Single byte: D=3, push 0xA5. One pop; tx_o = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. busy_o high for 40 cycles, then low.
- Back-to-back: D=1, FIFO holds 0x00,0xFF. Exactly 2 pops 20 cycles apart; stop of 2 cycles is followed directly by start; no idle cycle between frames.
- Divider latch: D=2 at start, change to 7 mid-frame. Current frame lasts 30 cycles; next frame uses 8 cycles per bit (80 cycles).
- Minimum divider: D=0, byte 0x81. tx_o = 0,1,0,0,0,0,0,0,1,1, one cycle each.
- Reset mid-frame: assert rst_i during the 4th data bit. Next cycle tx_o=1, busy_o=0, fifo_rd_en_o=0. After release with 0x3C queued, a clean 0x3C frame follows.
- UART_TX_PARITY_EN defined: byte 0x07 gives parity bit 1; byte 0x03 gives parity 0. Frame is 11 bit periods.
